// File: rtl/lut_interp_activation_if.sv
// Handshake, sample and table-write bundle for the piecewise-linear activation unit.
// The master drives samples and table writes; the slave is the activation unit.
interface lut_interp_activation_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2
);
  logic                      mode;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;

  modport master (
    output mode, in_valid, in_data, out_ready, wr_en, wr_addr, wr_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready, wr_en, wr_addr, wr_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_interp_activation.sv
// Three-stage piecewise-linear activation: table lookup, slope product, interpolation.
// All lanes share one runtime-writable breakpoint table and one valid/ready handshake.
module lut_interp_activation #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2
) (
  input logic                   clk,
  input logic                   rst,
  lut_interp_activation_if.slave bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0] MAX_POS = ADDR_W'((2 ** (ADDR_W - 1)) - 1);

  logic [DATA_W-1:0] r_lut [DEPTH];

  logic                    r_s1_valid;
  logic                    r_s1_mode;
  logic [DATA_W-1:0]       r_s1_base [LANES];
  logic [DATA_W-1:0]       r_s1_next [LANES];
  logic [FRAC_W-1:0]       r_s1_frac [LANES];

  logic                    r_s2_valid;
  logic                    r_s2_mode;
  logic [DATA_W-1:0]       r_s2_base [LANES];
  logic [PROD_W-1:0]       r_s2_prod [LANES];

  logic                    r_out_valid;
  logic [LANES*DATA_W-1:0] r_out_data;

  logic                    w_en;
  logic [ADDR_W-1:0]       w_addr      [LANES];
  logic [ADDR_W-1:0]       w_next_addr [LANES];
  logic [DATA_W:0]         w_diff      [LANES];
  logic [PROD_W-1:0]       w_prod      [LANES];
  logic [DATA_W-1:0]       w_y         [LANES];
  logic [LANES-1:0]        w_unused_prod;

  assign w_en          = bus.out_ready || !r_out_valid;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      w_addr[k] = bus.in_data[k*DATA_W+FRAC_W +: ADDR_W];
      // The largest positive segment has no successor, so it interpolates against itself.
      w_next_addr[k] = (w_addr[k] == MAX_POS) ? w_addr[k] : w_addr[k] + ADDR_W'(1);

      w_diff[k] = {r_s1_next[k][DATA_W-1], r_s1_next[k]}
                - {r_s1_base[k][DATA_W-1], r_s1_base[k]};
      // Low PROD_W bits of the signed product; the true product always fits.
      w_prod[k] = {{(FRAC_W+1){w_diff[k][DATA_W]}}, w_diff[k]}
                * {{(DATA_W+2){1'b0}}, r_s1_frac[k]};

      // Result lies between base and next, so dropping the upper product bits is exact.
      w_y[k] = r_s2_base[k] + r_s2_prod[k][FRAC_W +: DATA_W];
      w_unused_prod[k] = ^r_s2_prod[k][PROD_W-1:DATA_W+FRAC_W];
    end
  end

  // Writes land regardless of stall; S1 reads in the same cycle see the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_lut[i] <= (i < int'(DEPTH / 2)) ? DATA_W'(i << FRAC_W) : '0;
      end
    end else if (bus.wr_en) begin
      r_lut[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_mode   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int k = 0; k < int'(LANES); k++) begin
        r_s1_base[k] <= '0;
        r_s1_next[k] <= '0;
        r_s1_frac[k] <= '0;
        r_s2_base[k] <= '0;
        r_s2_prod[k] <= '0;
      end
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_mode   <= bus.mode;
      r_s2_valid  <= r_s1_valid;
      r_s2_mode   <= r_s1_mode;
      r_out_valid <= r_s2_valid;
      for (int k = 0; k < int'(LANES); k++) begin
        r_s1_base[k] <= r_lut[w_addr[k]];
        r_s1_next[k] <= r_lut[w_next_addr[k]];
        r_s1_frac[k] <= bus.in_data[k*DATA_W +: FRAC_W];
        r_s2_base[k] <= r_s1_base[k];
        r_s2_prod[k] <= w_prod[k];
        r_out_data[k*DATA_W +: DATA_W] <= r_s2_mode ? r_s2_base[k] : w_y[k];
      end
    end
  end
endmodule

// File: tb/tb_lut_interp_activation.sv
// Bench for lut_interp_activation: directed vectors, corner sequences and a randomized
// run scored against an arithmetic model of the table and interpolation rule.
module tb_lut_interp_activation;
  logic clk;
  logic rst;

  lut_interp_activation_if #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8), .LANES(2)) bus_if ();

  lut_interp_activation #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8), .LANES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic        m;
    logic [15:0] exp;
  } vec_t;

  int          total;
  int          bad;
  int          n_xfer;
  int          mlut [16];
  logic [15:0] sb_q [$];
  logic        stall_prev;
  logic [15:0] stall_data;
  vec_t        vecs [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic void reset_model();
    for (int i = 0; i < 16; i++) mlut[i] = (i < 8) ? i * 16 : 0;
  endfunction

  // Straight from the rule: y = base + floor((next-base)*frac/16), or base in step mode.
  function automatic logic [15:0] model(input logic [15:0] x, input logic m);
    logic [15:0] r;
    logic [7:0]  xb;
    int a, f, nidx, b, nx, d, qv, y;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      xb   = x[k*8 +: 8];
      a    = int'(xb[7:4]);
      f    = int'(xb[3:0]);
      nidx = (a == 7) ? 7 : (a + 1) % 16;
      b    = mlut[a];
      nx   = mlut[nidx];
      d    = (nx - b) * f;
      qv   = d / 16;
      if (d < 0 && d % 16 != 0) qv = qv - 1;
      y    = m ? b : b + qv;
      r[k*8 +: 8] = 8'(y);
    end
    return r;
  endfunction

  // Inputs are set at edge+1; everything is observed at edge+3 and scored here.
  task automatic tick();
    logic acc, xfer;
    #2;
    if (rst) begin
      sb_q.delete();
      reset_model();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bus_if.out_valid), 32'd1);
        chk("hold_data", 32'(bus_if.out_data), 32'(stall_data));
      end
      xfer = bus_if.out_valid && bus_if.out_ready;
      acc  = bus_if.in_valid && bus_if.in_ready;
      if (xfer) begin
        n_xfer++;
        chk("sb_expected_beat", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) chk("sb_data", 32'(bus_if.out_data), 32'(sb_q.pop_front()));
      end
      if (acc) sb_q.push_back(model(bus_if.in_data, bus_if.mode));
      if (bus_if.wr_en) mlut[bus_if.wr_addr] = int'($signed(bus_if.wr_data));
      stall_prev = bus_if.out_valid && !bus_if.out_ready;
      stall_data = bus_if.out_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_lut(input logic [3:0] a, input logic [7:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic send_expect(input logic [15:0] x, input logic m, input logic [15:0] exp,
                             input string nm, input logic we, input logic [3:0] wa,
                             input logic [7:0] wd);
    int n;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = x;
    bus_if.mode      = m;
    bus_if.wr_en     = we;
    bus_if.wr_addr   = wa;
    bus_if.wr_data   = wd;
    #1;
    n = 0;
    while (!bus_if.in_ready && n < 10) begin
      tick();
      n++;
    end
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.wr_en    = 1'b0;
    n = 1;
    while (!bus_if.out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd3);
    chk({nm, "_data"}, 32'(bus_if.out_data), 32'(exp));
    tick();
  endtask

  task automatic drain(input string nm);
    int n;
    bus_if.in_valid  = 1'b0;
    bus_if.wr_en     = 1'b0;
    bus_if.out_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] beats [5];
    int idx, cyc, x0;
    logic acc;

    total = 0;
    bad = 0;
    n_xfer = 0;
    stall_prev = 1'b0;
    stall_data = '0;
    reset_model();
    rst = 1'b1;
    bus_if.mode = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data = '0;
    bus_if.out_ready = 1'b1;
    bus_if.wr_en = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;

    vecs[0] = '{x: 16'h7535, m: 1'b0, exp: 16'h7035};
    vecs[1] = '{x: 16'h00F8, m: 1'b0, exp: 16'h0000};
    vecs[2] = '{x: 16'h4F28, m: 1'b0, exp: 16'h4F28};
    vecs[3] = '{x: 16'h6A7F, m: 1'b0, exp: 16'h6A70};
    vecs[4] = '{x: 16'h7F35, m: 1'b1, exp: 16'h7030};
    vecs[5] = '{x: 16'h1080, m: 1'b0, exp: 16'h1000};
    vecs[6] = '{x: 16'hFF6F, m: 1'b0, exp: 16'h006F};
    vecs[7] = '{x: 16'hEF90, m: 1'b0, exp: 16'h0000};

    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus_if.out_data), 32'd0);
    chk("reset_in_ready", 32'(bus_if.in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      send_expect(vecs[i].x, vecs[i].m, vecs[i].exp, $sformatf("vec%0d", i), 1'b0, 4'd0, 8'd0);
    end

    write_lut(4'd15, 8'hF0);
    send_expect(16'h00F8, 1'b0, 16'h00F8, "wrap_written", 1'b0, 4'd0, 8'd0);

    write_lut(4'd1, 8'h7F);
    write_lut(4'd2, 8'h80);
    send_expect(16'h001F, 1'b0, 16'h008F, "steep_neg", 1'b0, 4'd0, 8'd0);
    send_expect(16'h001F, 1'b1, 16'h007F, "steep_step", 1'b0, 4'd0, 8'd0);

    // Five back-to-back beats with a four-cycle downstream stall in the middle.
    beats[0] = 16'h1020;
    beats[1] = 16'h3040;
    beats[2] = 16'h5060;
    beats[3] = 16'h0A0B;
    beats[4] = 16'h6F01;
    x0 = n_xfer;
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 40) begin
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = beats[idx];
      bus_if.mode      = 1'b0;
      bus_if.out_ready = !(cyc >= 3 && cyc < 7);
      #1;
      acc = bus_if.in_ready;
      if (cyc >= 3 && cyc < 7) chk($sformatf("stall_in_ready_c%0d", cyc),
                                   32'(bus_if.in_ready), 32'd0);
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("stall_all_accepted", 32'(idx), 32'd5);
    drain("stall");
    chk("stall_beat_count", 32'(n_xfer - x0), 32'd5);

    send_expect(16'h0030, 1'b0, 16'h0030, "same_cycle_wr", 1'b1, 4'd3, 8'h00);
    send_expect(16'h0030, 1'b0, 16'h0000, "after_wr", 1'b0, 4'd0, 8'd0);

    // Reset with two beats in flight.
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 16'h0035;
    tick();
    bus_if.in_data   = 16'h0075;
    tick();
    bus_if.in_valid  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst_quiet%0d", i), 32'(bus_if.out_valid), 32'd0);
      tick();
    end
    send_expect(16'h0035, 1'b0, 16'h0035, "midrst_ramp", 1'b0, 4'd0, 8'd0);

    for (int i = 0; i < 400; i++) begin
      bus_if.in_valid  = ($urandom_range(0, 3) != 0);
      bus_if.in_data   = 16'($urandom);
      bus_if.mode      = ($urandom_range(0, 3) == 0);
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      bus_if.wr_en     = ($urandom_range(0, 7) == 0);
      bus_if.wr_addr   = 4'($urandom);
      bus_if.wr_data   = 8'($urandom);
      tick();
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lut_interp_activation.md
Name: lut_interp_activation

Overview:
- Pipelined, parametrised piecewise-linear activation unit for the NN datapath.
- Sits between a layer's accumulator/requantiser and the next layer's input.
- Uses a runtime-writable breakpoint table shared by LANES parallel lanes.
- Per lane, it reads a base and next breakpoint and linearly interpolates with the input's fractional bits; a step mode outputs base only.

Parameters:
- ADDR_W, 4, table index width; table depth = 2**ADDR_W entries.
- FRAC_W, 4, fractional input bits used for interpolation.
- DATA_W, 8, signed sample/table width; must equal ADDR_W+FRAC_W.
- LANES, 2, parallel lanes sharing one table and one handshake.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- mode, input, 1, 0 = interpolate, 1 = step; sampled with each accepted input.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, unit can accept a beat this cycle.
- in_data, input, LANES*DATA_W, signed samples; lane k = bits [k*DATA_W +: DATA_W].
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, LANES*DATA_W, signed activations, same lane packing as in_data.
- wr_en, input, 1, table write strobe.
- wr_addr, input, ADDR_W, table write index.
- wr_data, input, DATA_W, signed table entry.

Behaviour:
- Reset (sync, active-high):
  - out_valid=0, out_data=0, all stage valids 0.
  - Table loads the default ramp: lut[i] = i<<FRAC_W for i < 2**(ADDR_W-1), else 0 (entries 0,16,…,112,0…0 at defaults).
  - in_ready=1 in the cycle after reset deasserts.
  - rst mid-operation discards all in-flight beats and overwrites any prior writes.
- Index decode per lane:
  - addr = x[DATA_W-1:FRAC_W], read as two's complement; frac = x[FRAC_W-1:0], unsigned.
  - next index = addr+1 mod depth (all-ones wraps to 0), except addr = 2**(ADDR_W-1)-1 (max positive), where next index = addr (clamp).
- Pipeline: 3 stages, latency 3 cycles from accept to out_valid with no stall.
  - S1: register base = lut[addr], next = lut[next index], frac and mode.
  - S2: diff = next - base, DATA_W+1 bits signed; prod = diff * {0,frac}, signed, DATA_W+FRAC_W+2 bits.
  - S3: y = base + (prod >>> FRAC_W), arithmetic shift, floor rounding; in step mode, y = base.
  - y always lies between base and next, so it is truncated to DATA_W without saturation logic.
- Handshake:
  - Accept when in_valid && in_ready; output transfer when out_valid && out_ready.
  - Global enable en = out_ready || !out_valid, and in_ready = en.
  - When en=0, all stages hold. Bubbles are not collapsed.
  - out_data is held stable while out_valid && !out_ready.
- Table writes:
  - Registered; a write is visible to S1 reads from the next cycle.
  - A same-cycle write and read of the same index returns the old value.
  - Beats already past S1 are unaffected.
  - Writes are accepted regardless of stall state.
- Lanes are fully independent except for the shared table, mode and handshake.

Test Plan:
- Reset, lane0=0x35, lane1=0x75, mode=0, out_ready=1 -> 3 cycles later out lane0=53 (48+(16*5>>4)), lane1=112 (clamp at addr 7).
- lane0=0xF8 (addr 15 wraps to lut[0]), mode=0 -> 0. Then write lut[15]=0xF0 (-16) and resend 0xF8 -> -8.
- Write lut[1]=127, lut[2]=-128; send 0x1F -> 127+floor(-255*15/16) = 127-240 = -113. Same input with mode=1 -> 127.
- Five back-to-back beats with out_ready held low 4 cycles mid-stream -> in_ready drops, no beat lost or duplicated, order preserved, out_data stable while stalled.
- Same-cycle write lut[3]=0 with input 0x30 accepted -> output 48 (old value). Next beat 0x30 -> 0.
- Assert rst with 2 beats in flight -> out_valid=0 next cycle, no stale beat emerges, table back to ramp (0x35 -> 53).
